// File: rtl/bus_endpoint_fifo.sv
// Bus endpoint: TX FIFO presented to the bus arbiter (pndng/D_pop/pop) and an
// address-filtered RX FIFO for the local consumer, plus saturating error counters.
module bus_endpoint_fifo #(
   parameter int unsigned pckg_sz   = 16,
   parameter int unsigned fifo_size = 16,
   parameter logic [7:0]  id        = 8'h00,
   parameter logic [7:0]  broadcast = 8'hFF,
   localparam int unsigned aw       = $clog2(fifo_size),
   localparam int unsigned cw       = aw + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [pckg_sz-1:0] tx_data,
   input  logic               tx_valid,
   output logic               tx_ready,
   output logic               pndng,
   output logic [pckg_sz-1:0] D_pop,
   input  logic               pop,
   input  logic               push,
   input  logic [pckg_sz-1:0] D_push,
   output logic [pckg_sz-1:0] rx_data,
   output logic               rx_valid,
   input  logic               rx_ready,
   output logic [cw-1:0]      tx_count,
   output logic [cw-1:0]      rx_count,
   output logic [15:0]        rx_drop_cnt,
   output logic [15:0]        pop_err_cnt
);

   localparam logic [cw-1:0] depth = cw'(fifo_size);

   logic [pckg_sz-1:0] tx_mem [fifo_size];
   logic [pckg_sz-1:0] rx_mem [fifo_size];
   logic [aw-1:0]      tx_wr_ptr, tx_rd_ptr;
   logic [aw-1:0]      rx_wr_ptr, rx_rd_ptr;

   logic tx_wr, tx_rd, pop_err;
   logic hit, rx_rd, rx_wr, rx_drop;

   // Flags and heads depend only on registered state, never on this cycle's inputs.
   assign tx_ready = (tx_count < depth);
   assign pndng    = (tx_count != '0);
   assign rx_valid = (rx_count != '0);
   assign D_pop    = pndng    ? tx_mem[tx_rd_ptr] : '0;
   assign rx_data  = rx_valid ? rx_mem[rx_rd_ptr] : '0;

   assign tx_wr   = tx_valid & tx_ready;
   assign tx_rd   = pop & pndng;
   assign pop_err = pop & ~pndng;

   assign hit     = (D_push[pckg_sz-1 -: 8] == id) | (D_push[pckg_sz-1 -: 8] == broadcast);
   assign rx_rd   = rx_valid & rx_ready;
   // A same-cycle read frees a slot, so a full FIFO can still accept a push.
   assign rx_wr   = push & hit & ((rx_count < depth) | rx_rd);
   assign rx_drop = push & hit & ~(rx_count < depth) & ~rx_rd;

   // NOTE: storage has no reset; occupancy counts alone decide what is valid,
   // which keeps the arrays as plain RAM without a reset fan-out.
   always_ff @(posedge clk) begin
      if (tx_wr) tx_mem[tx_wr_ptr] <= tx_data;
      if (rx_wr) rx_mem[rx_wr_ptr] <= D_push;
   end

   // NOTE: all state below uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_wr_ptr   <= '0;
         tx_rd_ptr   <= '0;
         tx_count    <= '0;
         rx_wr_ptr   <= '0;
         rx_rd_ptr   <= '0;
         rx_count    <= '0;
         rx_drop_cnt <= '0;
         pop_err_cnt <= '0;
      end else begin
         if (tx_wr) tx_wr_ptr <= tx_wr_ptr + 1'b1;
         if (tx_rd) tx_rd_ptr <= tx_rd_ptr + 1'b1;
         case ({tx_wr, tx_rd})
            2'b10:   tx_count <= tx_count + 1'b1;
            2'b01:   tx_count <= tx_count - 1'b1;
            default: tx_count <= tx_count;
         endcase

         if (rx_wr) rx_wr_ptr <= rx_wr_ptr + 1'b1;
         if (rx_rd) rx_rd_ptr <= rx_rd_ptr + 1'b1;
         case ({rx_wr, rx_rd})
            2'b10:   rx_count <= rx_count + 1'b1;
            2'b01:   rx_count <= rx_count - 1'b1;
            default: rx_count <= rx_count;
         endcase

         if (pop_err && pop_err_cnt != 16'hFFFF) pop_err_cnt <= pop_err_cnt + 16'd1;
         if (rx_drop && rx_drop_cnt != 16'hFFFF) rx_drop_cnt <= rx_drop_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_bus_endpoint_fifo.sv
// Scoreboard bench for bus_endpoint_fifo (id=2): stimulus pushes expected packets,
// a negedge monitor pops and compares whenever the DUT hands a head over.
module tb_bus_endpoint_fifo;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] tx_data, D_pop, D_push, rx_data;
   logic        tx_valid, tx_ready, pndng, pop, push, rx_valid, rx_ready;
   logic [4:0]  tx_count, rx_count;
   logic [15:0] rx_drop_cnt, pop_err_cnt;

   int checks = 0;
   int errors = 0;

   logic [15:0] tx_exp[$];
   logic [15:0] rx_exp[$];
   int tx_occ, rx_occ, exp_err, exp_drop;

   bus_endpoint_fifo #(
      .pckg_sz(16), .fifo_size(DEPTH), .id(8'h02), .broadcast(8'hFF)
   ) dut (
      .clk(clk), .reset(reset),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .pndng(pndng), .D_pop(D_pop), .pop(pop),
      .push(push), .D_push(D_push),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_count(tx_count), .rx_count(rx_count),
      .rx_drop_cnt(rx_drop_cnt), .pop_err_cnt(pop_err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: whenever a head is consumed, it must be the oldest expected packet.
   always @(negedge clk) begin
      if (!reset && pop && pndng) begin
         check("tx_sb_nonempty", 32'(tx_exp.size() != 0), 32'd1);
         if (tx_exp.size() != 0) check("tx_data_order", 32'(D_pop), 32'(tx_exp.pop_front()));
      end
      if (!reset && rx_ready && rx_valid) begin
         check("rx_sb_nonempty", 32'(rx_exp.size() != 0), 32'd1);
         if (rx_exp.size() != 0) check("rx_data_order", 32'(rx_data), 32'(rx_exp.pop_front()));
      end
   end

   task automatic check_state();
      check("tx_count", 32'(tx_count), 32'(tx_occ));
      check("rx_count", 32'(rx_count), 32'(rx_occ));
      check("pndng", 32'(pndng), 32'(tx_occ != 0));
      check("rx_valid", 32'(rx_valid), 32'(rx_occ != 0));
      check("tx_ready", 32'(tx_ready), 32'(tx_occ < DEPTH));
      if (tx_occ == 0) check("d_pop_empty", 32'(D_pop), 32'd0);
      if (rx_occ == 0) check("rx_data_empty", 32'(rx_data), 32'd0);
      check("pop_err_cnt", 32'(pop_err_cnt), 32'(exp_err));
      check("rx_drop_cnt", 32'(rx_drop_cnt), 32'(exp_drop));
   endtask

   // One bus cycle: drive at posedge+1, check at negedge, update the reference model.
   task automatic step(input logic tv, input logic [15:0] td, input logic pp,
                       input logic ps, input logic [15:0] dp, input logic rr);
      bit hit, rd, wr;
      tx_valid = tv; tx_data = td; pop = pp;
      push = ps; D_push = dp; rx_ready = rr;
      @(negedge clk);
      check_state();
      wr = tv && (tx_occ < DEPTH);
      rd = pp && (tx_occ > 0);
      if (pp && tx_occ == 0 && exp_err < 16'hFFFF) exp_err++;
      if (wr) tx_exp.push_back(td);
      tx_occ = tx_occ + (wr ? 1 : 0) - (rd ? 1 : 0);
      hit = (dp[15:8] == 8'h02) || (dp[15:8] == 8'hFF);
      rd = rr && (rx_occ > 0);
      wr = ps && hit && ((rx_occ < DEPTH) || rd);
      if (ps && hit && !wr && exp_drop < 16'hFFFF) exp_drop++;
      if (wr) rx_exp.push_back(dp);
      rx_occ = rx_occ + (wr ? 1 : 0) - (rd ? 1 : 0);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < 2 * DEPTH && (tx_occ > 0 || rx_occ > 0); i++)
         step(1'b0, 16'h0, tx_occ > 0, 1'b0, 16'h0, rx_occ > 0);
   endtask

   task automatic do_reset(input int n);
      tx_valid = 1'b0; pop = 1'b0; push = 1'b0; rx_ready = 1'b0;
      tx_data = '0; D_push = '0;
      reset = 1'b1;
      tx_exp.delete(); rx_exp.delete();
      tx_occ = 0; rx_occ = 0; exp_err = 0; exp_drop = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check_state();
         @(posedge clk); #1;
      end
      reset = 1'b0;
   endtask

   logic [7:0] dests [4] = '{8'h02, 8'hFF, 8'h05, 8'h00};

   initial begin
      reset = 1'b1;
      tx_valid = 1'b0; pop = 1'b0; push = 1'b0; rx_ready = 1'b0;
      tx_data = '0; D_push = '0;
      @(posedge clk); #1;
      do_reset(5);
      idle(2);

      // TX fill past full, then drain past empty.
      for (int i = 0; i <= DEPTH; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, 16'h0, 1'b0);
      for (int i = 0; i <= DEPTH; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
      idle(1);

      // RX address filter.
      step(1'b0, 16'h0, 1'b0, 1'b1, 16'h02AB, 1'b0);
      step(1'b0, 16'h0, 1'b0, 1'b1, 16'h03CD, 1'b0);
      step(1'b0, 16'h0, 1'b0, 1'b1, 16'hFF11, 1'b0);
      idle(1);
      drain();

      // RX overflow: 18 pushes with no reader.
      for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 16'h0, 1'b0, 1'b1, 16'h0200 + 16'(i), 1'b0);
      idle(1);
      drain();

      // RX full with simultaneous read and push.
      for (int i = 0; i < DEPTH; i++) step(1'b0, 16'h0, 1'b0, 1'b1, 16'h0230 + 16'(i), 1'b0);
      step(1'b0, 16'h0, 1'b0, 1'b1, 16'h02EE, 1'b1);
      idle(1);
      drain();

      // TX write+pop at count 5.
      for (int i = 0; i < 5; i++) step(1'b1, 16'h0C00 + 16'(i), 1'b0, 1'b0, 16'h0, 1'b0);
      step(1'b1, 16'h0C05, 1'b1, 1'b0, 16'h0, 1'b0);
      idle(1);
      drain();

      // Random traffic through both FIFOs, never overflowing or popping empty.
      for (int i = 0; i < 200; i++) begin
         logic tv, pp, ps, rr;
         tv = ($urandom_range(1) == 1) && (tx_occ < DEPTH);
         pp = ($urandom_range(2) != 0) && (tx_occ > 0);
         ps = ($urandom_range(1) == 1) && (rx_occ < DEPTH);
         rr = ($urandom_range(2) != 0);
         step(tv, 16'($urandom), pp, ps, {dests[$urandom_range(3)], 8'($urandom)}, rr);
      end
      drain();

      // Reset mid-traffic discards everything; fresh packets follow cleanly.
      for (int i = 0; i < 6; i++) step(1'b1, 16'h0D00 + 16'(i), 1'b0, 1'b1, 16'h0250 + 16'(i), 1'b0);
      step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
      do_reset(5);
      step(1'b1, 16'h0A0A, 1'b0, 1'b1, 16'h02BB, 1'b0);
      idle(1);
      drain();
      idle(1);

      check("tx_sb_empty", 32'(tx_exp.size()), 32'd0);
      check("rx_sb_empty", 32'(rx_exp.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
